// File: rtl/cmp_pipe.sv
// Two-stage pipelined magnitude comparator with valid/ready handshakes on both sides.
// Optional event counters are compiled in when the macro CMP_STATS_EN is defined.
module cmp_pipe #(
  parameter int WIDTH   = 8,
  parameter int STATS_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_gt,
  output logic             out_eq,
  output logic             out_lt,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min
`ifdef CMP_STATS_EN
  ,
  input  logic               clr_stats,
  output logic [STATS_W-1:0] cnt_gt,
  output logic [STATS_W-1:0] cnt_eq,
  output logic [STATS_W-1:0] cnt_lt
`endif
);

  if (WIDTH < 1 || STATS_W < 1) begin : g_param_check
    $error("cmp_pipe: WIDTH and STATS_W must be >= 1");
  end

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_signed;

  logic             r_s2_valid;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_min;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_out_fire;
  logic [WIDTH-1:0] w_sign_flip;
  logic [WIDTH-1:0] w_a_key;
  logic [WIDTH-1:0] w_b_key;
  logic             w_gt;
  logic             w_lt;
  logic             w_eq;

  assign w_adv2     = !r_s2_valid || out_ready;
  assign w_adv1     = !r_s1_valid || w_adv2;
  assign in_ready   = rst_n && w_adv1;
  assign w_out_fire = r_s2_valid && out_ready;

  // Inverting the MSB maps two's-complement order onto unsigned order.
  assign w_sign_flip = WIDTH'(r_s1_signed) << (WIDTH - 1);
  assign w_a_key     = r_s1_a ^ w_sign_flip;
  assign w_b_key     = r_s1_b ^ w_sign_flip;
  assign w_gt        = w_a_key > w_b_key;
  assign w_lt        = w_a_key < w_b_key;
  assign w_eq        = r_s1_a == r_s1_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_signed <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a      <= in_a;
        r_s1_b      <= in_b;
        r_s1_signed <= in_signed;
      end
    end
  end

  // Result fields only update on a real pair so they keep their last value across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_gt       <= 1'b0;
      r_eq       <= 1'b0;
      r_lt       <= 1'b0;
      r_max      <= '0;
      r_min      <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_gt  <= w_gt;
        r_eq  <= w_eq;
        r_lt  <= w_lt;
        r_max <= w_lt ? r_s1_b : r_s1_a;
        r_min <= w_lt ? r_s1_a : r_s1_b;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_gt    = r_gt;
  assign out_eq    = r_eq;
  assign out_lt    = r_lt;
  assign out_max   = r_max;
  assign out_min   = r_min;

`ifdef CMP_STATS_EN
  logic [2:0] w_flag;
  assign w_flag = {r_gt, r_eq, r_lt};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [STATS_W-1:0] r_cnt;
    // A clear coinciding with a handshake still counts that event.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (clr_stats) begin
        r_cnt <= (w_out_fire && w_flag[gi]) ? STATS_W'(1) : '0;
      end else if (w_out_fire && w_flag[gi] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign cnt_gt = g_cnt[2].r_cnt;
  assign cnt_eq = g_cnt[1].r_cnt;
  assign cnt_lt = g_cnt[0].r_cnt;
`else
  logic w_unused_fire;
  assign w_unused_fire = w_out_fire;
`endif

endmodule

// File: tb/tb_cmp_pipe.sv
// Self-checking bench for cmp_pipe: scoreboard of expected results in acceptance order,
// plus per-scenario latency, backpressure, reset and WIDTH=1 checks.
module tb_cmp_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_signed = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready, out_valid, out_gt, out_eq, out_lt;
  logic [W-1:0] out_max, out_min;

  logic       w1_in_valid = 1'b0;
  logic       w1_in_signed = 1'b0;
  logic [0:0] w1_in_a = '0;
  logic [0:0] w1_in_b = '0;
  logic       w1_in_ready, w1_out_valid, w1_out_gt, w1_out_eq, w1_out_lt;
  logic [0:0] w1_out_max, w1_out_min;

`ifdef CMP_STATS_EN
  logic       clr_stats = 1'b0;
  logic [1:0] cnt_gt, cnt_eq, cnt_lt;
  cmp_pipe #(.WIDTH(W), .STATS_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_gt(out_gt), .out_eq(out_eq), .out_lt(out_lt),
    .out_max(out_max), .out_min(out_min),
    .clr_stats(clr_stats), .cnt_gt(cnt_gt), .cnt_eq(cnt_eq), .cnt_lt(cnt_lt)
  );
`else
  cmp_pipe #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_gt(out_gt), .out_eq(out_eq), .out_lt(out_lt),
    .out_max(out_max), .out_min(out_min)
  );
`endif

`ifdef CMP_STATS_EN
  logic       w1_clr = 1'b0;
  logic [1:0] w1_cg, w1_ce, w1_cl;
  cmp_pipe #(.WIDTH(1), .STATS_W(2)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .in_a(w1_in_a), .in_b(w1_in_b), .in_signed(w1_in_signed),
    .out_valid(w1_out_valid), .out_ready(1'b1),
    .out_gt(w1_out_gt), .out_eq(w1_out_eq), .out_lt(w1_out_lt),
    .out_max(w1_out_max), .out_min(w1_out_min),
    .clr_stats(w1_clr), .cnt_gt(w1_cg), .cnt_eq(w1_ce), .cnt_lt(w1_cl)
  );
`else
  cmp_pipe #(.WIDTH(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .in_a(w1_in_a), .in_b(w1_in_b), .in_signed(w1_in_signed),
    .out_valid(w1_out_valid), .out_ready(1'b1),
    .out_gt(w1_out_gt), .out_eq(w1_out_eq), .out_lt(w1_out_lt),
    .out_max(w1_out_max), .out_min(w1_out_min)
  );
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic         gt;
    logic         eq;
    logic         lt;
    logic [W-1:0] mx;
    logic [W-1:0] mn;
  } res_t;

  res_t exp_q[$];
  res_t act_q[$];
  int   act_cyc[$];
  res_t mon_r;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic s);
    res_t r;
    logic g, l;
    if (s) begin
      g = $signed(a) > $signed(b);
      l = $signed(a) < $signed(b);
    end else begin
      g = a > b;
      l = a < b;
    end
    r.gt = g;
    r.lt = l;
    r.eq = (a == b);
    r.mx = l ? b : a;
    r.mn = l ? a : b;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Expected results are queued at acceptance; pairs still in flight at reset are dropped.
  always @(negedge clk) begin
    if (!rst_n) begin
      while (exp_q.size() > act_q.size()) void'(exp_q.pop_back());
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_signed));
      if (out_valid && out_ready) begin
        mon_r.gt = out_gt;
        mon_r.eq = out_eq;
        mon_r.lt = out_lt;
        mon_r.mx = out_max;
        mon_r.mn = out_min;
        act_q.push_back(mon_r);
        act_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair and returns after the edge that accepts it (or after a timeout).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output bit ok);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    ok        = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'h33;
    in_b      = 8'h11;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_handshake cycle %0d: in_ready=%b out_valid=%b, required 0/0", c, in_ready, out_valid);
      end
    end
    vectors++;
    if ({out_gt, out_eq, out_lt} !== 3'b000 || out_max !== '0 || out_min !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: flags=%b max=%h min=%h, required 000/00/00", {out_gt, out_eq, out_lt}, out_max, out_min);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
  endtask

  task automatic test_signed_mode();
    bit ok;
    send(8'h80, 8'h01, 1'b0, ok);
    vectors++;
    if (!ok || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL unsigned_early: accepted=%b out_valid=%b, required 1/0", ok, out_valid);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || {out_gt, out_eq, out_lt} !== 3'b100 || out_max !== 8'h80 || out_min !== 8'h01) begin
      miscompares++;
      $display("FAIL unsigned_80_01: valid=%b flags=%b max=%h min=%h, required 1/100/80/01", out_valid, {out_gt, out_eq, out_lt}, out_max, out_min);
    end
    send(8'h80, 8'h01, 1'b1, ok);
    step();
    vectors++;
    if (!ok || out_valid !== 1'b1 || {out_gt, out_eq, out_lt} !== 3'b001 || out_max !== 8'h01 || out_min !== 8'h80) begin
      miscompares++;
      $display("FAIL signed_80_01: valid=%b flags=%b max=%h min=%h, required 1/001/01/80", out_valid, {out_gt, out_eq, out_lt}, out_max, out_min);
    end
    step();
  endtask

  task automatic test_equal_stream();
    bit ok;
    bit all_ok;
    int base, nlt, neq, ngt;
    send(8'h5A, 8'h5A, 1'b0, ok);
    step();
    vectors++;
    if (!ok || out_valid !== 1'b1 || {out_gt, out_eq, out_lt} !== 3'b010 || out_max !== 8'h5A || out_min !== 8'h5A) begin
      miscompares++;
      $display("FAIL equal_5A: valid=%b flags=%b max=%h min=%h, required 1/010/5a/5a", out_valid, {out_gt, out_eq, out_lt}, out_max, out_min);
    end
    step();
    base   = act_q.size();
    all_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(W'(i), 8'd5, 1'b0, ok);
      all_ok &= ok;
    end
    step();
    step();
    vectors++;
    if (!all_ok || act_q.size() - base != 10) begin
      miscompares++;
      $display("FAIL stream_count: accepted_all=%b results=%0d, required 1/10", all_ok, act_q.size() - base);
    end else begin
      nlt = 0; neq = 0; ngt = 0;
      for (int i = base; i < base + 10; i++) begin
        nlt += int'(act_q[i].lt);
        neq += int'(act_q[i].eq);
        ngt += int'(act_q[i].gt);
      end
      vectors++;
      if (nlt != 5 || neq != 1 || ngt != 4) begin
        miscompares++;
        $display("FAIL stream_flags: lt=%0d eq=%0d gt=%0d, required 5/1/4", nlt, neq, ngt);
      end
      vectors++;
      if (act_cyc[base + 9] - act_cyc[base] != 9) begin
        miscompares++;
        $display("FAIL stream_throughput: span=%0d cycles, required 9", act_cyc[base + 9] - act_cyc[base]);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc, base;
    logic [3+2*W:0] snap;
    base      = act_q.size();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'hC0;
    in_b      = 8'h40;
    in_signed = 1'b1;
    acc       = 0;
    snap      = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (in_ready) acc++;
      if (c == 2) snap = {out_valid, out_gt, out_eq, out_lt, out_max, out_min};
      @(posedge clk);
      #1;
      in_a = in_a + 8'h11;
      in_b = in_b - 8'h23;
    end
    vectors++;
    if (acc != 2 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accept: accepted=%0d in_ready=%b, required 2/0", acc, in_ready);
    end
    in_valid = 1'b0;
    step();
    step();
    vectors++;
    if (snap[3+2*W] !== 1'b1 || {out_valid, out_gt, out_eq, out_lt, out_max, out_min} !== snap) begin
      miscompares++;
      $display("FAIL bp_stable: outputs=%h snapshot=%h, required equal with valid=1", {out_valid, out_gt, out_eq, out_lt, out_max, out_min}, snap);
    end
    out_ready = 1'b1;
    repeat (4) step();
    vectors++;
    if (act_q.size() - base != 2) begin
      miscompares++;
      $display("FAIL bp_release: results=%0d, required 2", act_q.size() - base);
    end
  endtask

  task automatic test_reset_midstream();
    bit ok1, ok2;
    int n;
    out_ready = 1'b0;
    send(8'hA0, 8'h0A, 1'b0, ok1);
    send(8'h0B, 8'hB0, 1'b0, ok2);
    vectors++;
    if (!ok1 || !ok2 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_fill: acc=%b%b out_valid=%b in_ready=%b, required 11/1/0", ok1, ok2, out_valid, in_ready);
    end
    rst_n = 1'b0;
    step();
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    n         = act_q.size();
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_flush cycle %0d: out_valid=%b, required 0", c, out_valid);
      end
      step();
    end
    send(8'h07, 8'h03, 1'b0, ok1);
    vectors++;
    if (!ok1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_early: accepted=%b out_valid=%b, required 1/0", ok1, out_valid);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || {out_gt, out_eq, out_lt} !== 3'b100 || out_max !== 8'h07 || out_min !== 8'h03) begin
      miscompares++;
      $display("FAIL midrst_latency: valid=%b flags=%b max=%h min=%h, required 1/100/07/03", out_valid, {out_gt, out_eq, out_lt}, out_max, out_min);
    end
    step();
    vectors++;
    if (act_q.size() != n + 1) begin
      miscompares++;
      $display("FAIL midrst_count: results=%0d, required %0d", act_q.size(), n + 1);
    end
  endtask

  task automatic test_width1();
    w1_in_valid  = 1'b1;
    w1_in_a      = 1'b1;
    w1_in_b      = 1'b0;
    w1_in_signed = 1'b1;
    step();
    w1_in_valid = 1'b0;
    step();
    vectors++;
    if (w1_out_valid !== 1'b1 || {w1_out_gt, w1_out_eq, w1_out_lt} !== 3'b001 || w1_out_max !== 1'b0 || w1_out_min !== 1'b1) begin
      miscompares++;
      $display("FAIL w1_signed: valid=%b flags=%b max=%b min=%b, required 1/001/0/1", w1_out_valid, {w1_out_gt, w1_out_eq, w1_out_lt}, w1_out_max, w1_out_min);
    end
    w1_in_valid  = 1'b1;
    w1_in_signed = 1'b0;
    step();
    w1_in_valid = 1'b0;
    step();
    vectors++;
    if (w1_out_valid !== 1'b1 || {w1_out_gt, w1_out_eq, w1_out_lt} !== 3'b100 || w1_out_max !== 1'b1 || w1_out_min !== 1'b0) begin
      miscompares++;
      $display("FAIL w1_unsigned: valid=%b flags=%b max=%b min=%b, required 1/100/1/0", w1_out_valid, {w1_out_gt, w1_out_eq, w1_out_lt}, w1_out_max, w1_out_min);
    end
    step();
  endtask

`ifdef CMP_STATS_EN
  task automatic test_stats();
    bit ok;
    int t;
    out_ready = 1'b1;
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h20 + W'(i), 8'h10, 1'b0, ok);
    repeat (3) step();
    vectors++;
    if (cnt_gt !== 2'd3) begin
      miscompares++;
      $display("FAIL stats_saturate: cnt_gt=%0d, required 3", cnt_gt);
    end
    out_ready = 1'b0;
    send(8'h44, 8'h44, 1'b0, ok);
    t = 0;
    while (out_valid !== 1'b1 && t < 10) begin
      step();
      t++;
    end
    out_ready = 1'b1;
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    vectors++;
    if (cnt_gt !== 2'd0 || cnt_eq !== 2'd1 || cnt_lt !== 2'd0) begin
      miscompares++;
      $display("FAIL stats_clear: gt=%0d eq=%0d lt=%0d, required 0/1/0", cnt_gt, cnt_eq, cnt_lt);
    end
    step();
  endtask
`endif

  task automatic test_scoreboard();
    int n;
    repeat (3) step();
    vectors++;
    if (exp_q.size() != act_q.size()) begin
      miscompares++;
      $display("FAIL sb_count: results=%0d, required %0d", act_q.size(), exp_q.size());
    end
    n = (exp_q.size() < act_q.size()) ? exp_q.size() : act_q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL sb_result[%0d]: got flags=%b max=%h min=%h, required flags=%b max=%h min=%h", i,
                 {act_q[i].gt, act_q[i].eq, act_q[i].lt}, act_q[i].mx, act_q[i].mn,
                 {exp_q[i].gt, exp_q[i].eq, exp_q[i].lt}, exp_q[i].mx, exp_q[i].mn);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_signed_mode();
    test_equal_stream();
    test_backpressure();
    test_reset_midstream();
    test_width1();
`ifdef CMP_STATS_EN
    test_stats();
`endif
    test_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
